// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 size
// codes and data-memory geometry.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } lsu_state_e;

    // funct3[1:0] access size; 2'b11 is handled as a word.
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int MEM_WORDS = 1024;

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half out of the memory
// word and sign- or zero-extends it (funct3[2]=1 means unsigned).
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] sh_b;
    logic [31:0] sh_h;

    // Lane extraction and extension.
    always_comb begin
        sh_b   = data >> {offset, 3'b000};
        sh_h   = data >> {offset[1], 4'b0000};
        result = data;
        case (funct3[1:0])
            SZ_B:    result = funct3[2] ? {24'h0, sh_b[7:0]}
                                        : {{24{sh_b[7]}}, sh_b[7:0]};
            SZ_H:    result = funct3[2] ? {16'h0, sh_h[15:0]}
                                        : {{16{sh_h[15]}}, sh_h[15:0]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a word-addressed, byte-enabled data memory
// with one-cycle registered read. One access in flight, three-cycle
// turnaround (accept, issue, respond).
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/W accesses are flagged and never touch memory
//   undefined : offending low address bits are masked and the access
//               proceeds aligned; out_lsu_misaligned is tied 0
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready; latch request on valid
// ST_ISSUE | drive memory from latched fields (write happens this cycle)
// ST_RESP  | done pulse; load result taken from registered mem data
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              in_lsu_valid,
    output logic              out_lsu_ready,
    input  logic              in_lsu_is_store,
    input  logic [2:0]        in_lsu_funct3,
    input  logic [ADDR_W-1:0] in_lsu_addr,
    input  logic [31:0]       in_lsu_wdata,
    output logic              out_lsu_done,
    output logic [31:0]       out_lsu_rdata,
    output logic              out_lsu_misaligned,
    output logic [ADDR_W-3:0] out_mem_addr,
    output logic              out_mem_rw_mode,
    output logic [31:0]       out_mem_write_data,
    output logic [3:0]        out_mem_byte_en,
    input  logic [31:0]       in_mem_data
);

    lsu_state_e        state_q;
    logic              store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mis_q;

    logic [ADDR_W-1:0] acc_addr;
    logic              acc_mis;
    logic [3:0]        acc_be;
    logic [31:0]       acc_wdata;
    logic [31:0]       align_rdata;

    // Request decode: alignment handling, byte enables and lane replication.
    always_comb begin
        acc_addr  = in_lsu_addr;
        acc_mis   = 1'b0;
        acc_be    = 4'hF;
        acc_wdata = in_lsu_wdata;
        case (in_lsu_funct3[1:0])
            SZ_B: begin
                acc_be    = 4'b0001 << acc_addr[1:0];
                acc_wdata = {4{in_lsu_wdata[7:0]}};
            end
            SZ_H: begin
                if (in_lsu_addr[0]) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    acc_mis = 1'b1;
`else
                    acc_addr[0] = 1'b0;
`endif
                end
                acc_be    = 4'b0011 << {acc_addr[1], 1'b0};
                acc_wdata = {2{in_lsu_wdata[15:0]}};
            end
            default: begin
                if (in_lsu_addr[1:0] != 2'b00) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    acc_mis = 1'b1;
`else
                    acc_addr[1:0] = 2'b00;
`endif
                end
                acc_be    = 4'hF;
                acc_wdata = in_lsu_wdata;
            end
        endcase
        if (acc_mis) begin
            acc_be = 4'h0;
        end
    end

    // Sequencer and request latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q            <= ST_IDLE;
            store_q            <= 1'b0;
            funct3_q           <= 3'b000;
            addr_q             <= '0;
            mis_q              <= 1'b0;
            out_mem_byte_en    <= 4'h0;
            out_mem_write_data <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_lsu_valid) begin
                        store_q            <= in_lsu_is_store;
                        funct3_q           <= in_lsu_funct3;
                        addr_q             <= acc_addr;
                        mis_q              <= acc_mis;
                        out_mem_byte_en    <= acc_be;
                        out_mem_write_data <= acc_wdata;
                        state_q            <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state_q <= ST_RESP;
                ST_RESP:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    lsu_load_align u_load_align (
        .data   (in_mem_data),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .result (align_rdata)
    );

    assign out_lsu_ready   = (state_q == ST_IDLE);
    assign out_mem_addr    = addr_q[ADDR_W-1:2];
    // Reset forces read so an interrupted store never lands.
    assign out_mem_rw_mode = i_rst | ~((state_q == ST_ISSUE) & store_q & ~mis_q);
    assign out_lsu_done    = (state_q == ST_RESP) & ~i_rst;
    assign out_lsu_rdata   = (out_lsu_done & ~store_q & ~mis_q) ? align_rdata : 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
    assign out_lsu_misaligned = out_lsu_done & mis_q;
`else
    assign out_lsu_misaligned = 1'b0;
`endif

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the data memory (word-addressed, 1024×32, byte-enabled, one-cycle registered read, `rw_mode` 1=read/0=write). Accepts one RISC-V load or store per request and converts its byte address and funct3 into a word address, byte enables, and a lane-replicated write word. On loads, captures the memory's registered read data and returns the lane-extracted, sign- or zero-extended result. Fixed three-cycle turnaround, one outstanding access.

## Interface
- `ADDR_W`, 12: byte-address width; memory word address is `ADDR_W-2` bits.
- `i_clk` in 1: clock.
- `i_rst` in 1: synchronous, active-high reset.
- `in_lsu_valid` in 1: request valid.
- `out_lsu_ready` out 1: request can be accepted; high only in IDLE.
- `in_lsu_is_store` in 1: 1=store, 0=load.
- `in_lsu_funct3` in 3: RISC-V funct3: `[1:0]` size (00 B, 01 H, 10 W, 11 treated as W); `[2]` unsigned (loads only, ignored on stores).
- `in_lsu_addr` in ADDR_W: byte address.
- `in_lsu_wdata` in 32: store data, right-aligned.
- `out_lsu_done` out 1: one-cycle completion pulse.
- `out_lsu_rdata` out 32: load result; valid with `out_lsu_done` on loads, 0 otherwise.
- `out_lsu_misaligned` out 1: misalignment flag, valid with `out_lsu_done`.
- `out_mem_addr` out ADDR_W-2: word address to memory.
- `out_mem_rw_mode` out 1: 1=read, 0=write.
- `out_mem_write_data` out 32: lane-replicated store word.
- `out_mem_byte_en` out 4: byte enables.
- `in_mem_data` in 32: memory registered read data.

## Operation
- FSM: IDLE → ISSUE → RESP → IDLE. Accept on an edge where `in_lsu_valid && out_lsu_ready`. Latch store flag, funct3, address, and wdata, then go to ISSUE. Without valid, stay in IDLE.
- ISSUE: drive the memory from latched fields. On a store, `rw_mode=0`; the memory writes at the end of the cycle. On a load, `rw_mode=1`; the memory captures the word at the end of the cycle.
- RESP: `out_lsu_done=1`. On a load, `out_lsu_rdata` is combinational from `in_mem_data` and the latched offset/funct3. Return to IDLE on the next edge.
- `out_mem_rw_mode` is 1 in every state except ISSUE-with-store. It is also forced to 1 whenever `i_rst=1`, so a reset during ISSUE suppresses the write.
- `out_mem_addr` = latched `addr[ADDR_W-1:2]`, held in all states. Reset value 0.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'hF`.
  - Misaligned (when trapped): `4'h0`.
- Write data:
  - B: `{4{wdata[7:0]}}`.
  - H: `{2{wdata[15:0]}}`.
  - W: `wdata`.
- Load extract:
  - B: `in_mem_data >> (8*addr[1:0])`, low byte.
  - H: `in_mem_data >> (16*addr[1])`, low half.
  - Sign-extend when `funct3[2]=0`, zero-extend when 1.
- Reset (synchronous): state=IDLE; all latched fields 0; `out_lsu_done=0`; `out_lsu_rdata=0`; `out_lsu_misaligned=0`; `out_mem_rw_mode=1`; `out_mem_byte_en=0`; `out_mem_write_data=0`. An access in flight is dropped with no done pulse.

## Timing
- Request accepted at edge E0 → ISSUE during cycle E0..E1 → RESP (done) during E1..E2 → ready again after E2.
- Done is two cycles after accept. Throughput is one access per 3 cycles.
- A store is architecturally visible from E1; a load issued immediately after it returns the new data.
- `out_lsu_ready` deasserts the cycle after acceptance. The requester must hold nothing after the accept edge.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - H with `addr[0]=1`, or W with `addr[1:0]≠0`, is misaligned.
  - It still takes the ISSUE and RESP cycles, but `rw_mode` stays 1 and `byte_en` is 0.
  - RESP asserts `out_lsu_misaligned=1` with `out_lsu_rdata=0`.
- Undefined: the offending low address bits are masked (H clears bit 0, W clears bits 1:0). The access proceeds aligned and `out_lsu_misaligned` is tied 0.

## Structure
- `lsu_pkg`:
  - FSM state enum.
  - funct3 size constants (`SZ_B`, `SZ_H`, `SZ_W`).
  - `MEM_WORDS=1024`.
- Sub-module `lsu_load_align`: combinational extract and sign/zero extension from (data, offset, funct3) to a 32-bit result.

## Test plan
- SW `0xDEADBEEF` @0x010, then LW @0x010 → `rdata=0xDEADBEEF`. Store writes at E1, with `byte_en=F` and `mem_addr=4`.
- SB `0x80` @0x013, then LB @0x013 → `0xFFFFFF80`; LBU @0x013 → `0x00000080`; LW @0x010 → `0x80ADBEEF`.
- SH `0x1234` @0x012: `byte_en=1100`, `write_data=0x12341234`. Then LH @0x012 → `0x00001234`.
- LW @0x011:
  - With `LSU_MISALIGN_TRAP_EN`: `misaligned=1`, `rdata=0`, no write.
  - Without: reads word 4, `misaligned=0`.
- `i_rst` asserted during ISSUE of SW `0xFFFFFFFF` @0x020: no write (later LW @0x020 shows old value), no done pulse, `ready=1` the next cycle.
- Back-to-back valid held high for 3 requests → accepts spaced exactly 3 cycles apart, one done per request, in order.
